// File: rtl/mult_pkg.sv
// Shared types and constants for the Booth radix-2 multiplier:
// the control bundle that the controller drives into the datapath, the controller
// state encoding, and the Booth pair encodings that request an add or a subtract.
package mult_pkg;

  typedef struct packed {
    logic load_A;
    logic load_B;
    logic load_add;
    logic add_sub;
    logic shift_HQ_LQ_Q_1;
  } mult_control_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EVAL,
    SHIFT,
    DONE
  } mult_state_t;

  // {Q0, Q_-1} pairs. 01 adds the multiplicand to HQ and 10 subtracts it.
  // 00 and 11 leave HQ unchanged.
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/mult_datapath.sv
// Shift-add Booth datapath. M holds the multiplicand and is sign-extended by one bit.
// HQ is an N+1-bit accumulator, LQ holds the multiplier, and Q_1 holds the bit most
// recently shifted out. The extra HQ bit keeps the result correct when subtracting
// the most negative multiplicand.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     i_A,
  input  logic [N-1:0]     i_B,
  input  mult_control_t    i_control,
  output logic [1:0]       o_qLsb,
  output logic [2*N-1:0]   o_Y
);

  logic [N:0]   r_HQ;
  logic [N:0]   r_M;
  logic [N-1:0] r_LQ;
  logic         r_Q1;
  logic [N:0]   w_sum;

  // Accumulator update. add_sub=1 adds M and add_sub=0 subtracts it.
  always_comb begin
    w_sum = i_control.add_sub ? (r_HQ + r_M) : (r_HQ - r_M);
  end

  // Operand load, accumulate, and arithmetic right shift of {HQ, LQ, Q_1}.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_HQ <= '0;
      r_M  <= '0;
      r_LQ <= '0;
      r_Q1 <= 1'b0;
    end else begin
      if (i_control.load_A) begin
        r_LQ <= i_A;
        r_HQ <= '0;
        r_Q1 <= 1'b0;
      end
      if (i_control.load_B) begin
        r_M <= {i_B[N-1], i_B};
      end
      if (i_control.load_add) begin
        r_HQ <= w_sum;
      end
      if (i_control.shift_HQ_LQ_Q_1) begin
        {r_HQ, r_LQ, r_Q1} <= {r_HQ[N], r_HQ, r_LQ};
      end
    end
  end

  assign o_qLsb = {r_LQ[0], r_Q1};
  assign o_Y    = {r_HQ[N-1:0], r_LQ};

endmodule

// File: rtl/mult_top.sv
// Integration wrapper. It connects the Booth controller to its shift-add datapath.
// The signed product appears on o_Y in the cycle where o_done pulses.
module mult_top
  import mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [N-1:0]   i_A,
  input  logic [N-1:0]   i_B,
  output logic           o_busy,
  output logic           o_done,
  output logic [2*N-1:0] o_Y
);

  mult_control_t w_control;
  logic [1:0]    w_qLsb;

  mult_controller #(.N(N)) u_controller (
    .clk          (clk),
    .rst          (rst),
    .start        (i_start),
    .Q_LSB        (w_qLsb),
    .mult_control (w_control),
    .busy         (o_busy),
    .done         (o_done)
  );

  mult_datapath #(.N(N)) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .i_A       (i_A),
    .i_B       (i_B),
    .i_control (w_control),
    .o_qLsb    (w_qLsb),
    .o_Y       (o_Y)
  );

endmodule

// File: rtl/mult_controller.sv
// Booth radix-2 sequencer. It issues one load, then N evaluate/shift pairs, then a
// single-cycle done pulse. The evaluate step decodes {Q0, Q_-1} combinationally, so
// the add/subtract request is issued in the same cycle that the pair is presented.
module mult_controller
  import mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    Q_LSB,
  output mult_control_t mult_control,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  mult_state_t   r_state;
  mult_state_t   w_nextState;
  logic [CW-1:0] r_count;

  // State register. An asynchronous reset abandons any operation that is in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Iteration counter. LOAD clears it and each SHIFT advances it by one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else begin
      case (r_state)
        LOAD:    r_count <= '0;
        SHIFT:   r_count <= r_count + CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Next-state and output decode. Any unrecognised Q_LSB pair in EVAL is treated as a no-op.
  always_comb begin
    w_nextState  = r_state;
    mult_control = '0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = LOAD;
        end
      end
      LOAD: begin
        busy                = 1'b1;
        mult_control.load_A = 1'b1;
        mult_control.load_B = 1'b1;
        w_nextState         = EVAL;
      end
      EVAL: begin
        busy = 1'b1;
        case (Q_LSB)
          BOOTH_ADD: begin
            mult_control.load_add = 1'b1;
            mult_control.add_sub  = 1'b1;
          end
          BOOTH_SUB: begin
            mult_control.load_add = 1'b1;
            mult_control.add_sub  = 1'b0;
          end
          default: begin
            mult_control.load_add = 1'b0;
            mult_control.add_sub  = 1'b0;
          end
        endcase
        w_nextState = SHIFT;
      end
      SHIFT: begin
        busy                         = 1'b1;
        mult_control.shift_HQ_LQ_Q_1 = 1'b1;
        w_nextState = (r_count == LAST_ITER) ? DONE : EVAL;
      end
      DONE: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // A shift must never coincide with any register load.
  a_noShiftOverlap: assert property (@(posedge clk) disable iff (!rst)
    mult_control.shift_HQ_LQ_Q_1 |->
      !(mult_control.load_A || mult_control.load_B || mult_control.load_add));

  // done is a single-cycle pulse.
  a_doneSingle: assert property (@(posedge clk) disable iff (!rst)
    done |=> !done);

  // busy and done are mutually exclusive.
  a_busyDoneExclusive: assert property (@(posedge clk) disable iff (!rst)
    !(busy && done));

  // The datapath must present a known Booth pair during evaluation.
  a_qLsbKnown: assert property (@(posedge clk) disable iff (!rst)
    (r_state == EVAL) |-> !$isunknown(Q_LSB));

endmodule

// File: tb/tb_mult_controller.sv
// Directed bench for the Booth controller. The controller is paired with the
// datapath, and a mux can override Q_LSB so that control traces can be pinned down.
module tb_mult_controller;
  import mult_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          forceQ;
  logic [1:0]    forcedQ;
  logic [1:0]    dpQ;
  logic [1:0]    ctlQ;
  mult_control_t ctl;
  logic          busy;
  logic          done;
  logic [7:0]    opA;
  logic [7:0]    opB;
  logic [15:0]   y;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  assign ctlQ = forceQ ? forcedQ : dpQ;

  mult_controller #(.N(8)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .Q_LSB        (ctlQ),
    .mult_control (ctl),
    .busy         (busy),
    .done         (done)
  );

  mult_datapath #(.N(8)) u_dp (
    .clk       (clk),
    .rst       (rst),
    .i_A       (opA),
    .i_B       (opB),
    .i_control (ctl),
    .o_qLsb    (dpQ),
    .o_Y       (y)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to 2ns after the next rising edge. Outputs are sampled there.
  task automatic step();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  // Present start for one edge. The caller is left in cycle 1 (LOAD).
  task automatic startOp();
    start = 1'b1;
    step();
    cyc   = 1;
    start = 1'b0;
  endtask

  // Step until done, with a bound. Check the cycle in which done arrives.
  task automatic runToDone(input string name, input int expCyc);
    while (!done && cyc < expCyc + 20) step();
    checks++;
    if (!done) begin
      $display("[TB] FAIL %s_timeout: got no done by cycle %0d, expected done at %0d", name, cyc, expCyc);
      errors++;
    end else if (cyc != expCyc) begin
      $display("[TB] FAIL %s_doneCycle: got %0d expected %0d", name, cyc, expCyc);
      errors++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; forceQ = 1'b1; forcedQ = 2'b00; opA = '0; opB = '0;
    #1 rst = 1'b0;
    #2;
    checks++;
    if ({ctl, busy, done} !== 7'b0) begin
      $display("[TB] FAIL reset_outputs: got %b expected %b", {ctl, busy, done}, 7'b0);
      errors++;
    end
    start = 1'b1;
    step();
    checks++;
    if ({ctl, busy, done} !== 7'b0) begin
      $display("[TB] FAIL reset_holdsIdle: got %b expected %b", {ctl, busy, done}, 7'b0);
      errors++;
    end
    start = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({ctl, busy, done} !== 7'b0) begin
        $display("[TB] FAIL reset_idleAfterRelease: got %b expected %b", {ctl, busy, done}, 7'b0);
        errors++;
      end
    end
  endtask

  task automatic test_controlTrace();
    forceQ = 1'b1; forcedQ = 2'b00;
    startOp();
    checks++;
    if ({ctl, busy, done} !== 7'b11000_1_0) begin
      $display("[TB] FAIL trace_load: got %b expected %b", {ctl, busy, done}, 7'b11000_1_0);
      errors++;
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if ({ctl, busy, done} !== 7'b00000_1_0) begin
        $display("[TB] FAIL trace_eval%0d: got %b expected %b", i, {ctl, busy, done}, 7'b00000_1_0);
        errors++;
      end
      step();
      checks++;
      if ({ctl, busy, done} !== 7'b00001_1_0) begin
        $display("[TB] FAIL trace_shift%0d: got %b expected %b", i, {ctl, busy, done}, 7'b00001_1_0);
        errors++;
      end
    end
    step();
    checks++;
    if (cyc != 18 || {ctl, busy, done} !== 7'b00000_0_1) begin
      $display("[TB] FAIL trace_done: got %b at cycle %0d expected %b at 18", {ctl, busy, done}, cyc, 7'b00000_0_1);
      errors++;
    end
    step();
    checks++;
    if ({ctl, busy, done} !== 7'b0) begin
      $display("[TB] FAIL trace_idle: got %b expected %b", {ctl, busy, done}, 7'b0);
      errors++;
    end
  endtask

  task automatic test_boothDecode();
    logic [1:0] pats [4];
    logic [1:0] exps [4];
    pats = '{2'b10, 2'b01, 2'b11, 2'b00};
    exps = '{2'b10, 2'b11, 2'b00, 2'b00};
    forceQ = 1'b1; forcedQ = 2'b00;
    startOp();
    step();
    for (int i = 0; i < 4; i++) begin
      forcedQ = pats[i];
      #1;
      checks++;
      if ({ctl.load_add, ctl.add_sub} !== exps[i] || ctl.shift_HQ_LQ_Q_1 !== 1'b0) begin
        $display("[TB] FAIL booth_q%b: got add=%b sub=%b sh=%b expected %b sh=0", pats[i],
                 ctl.load_add, ctl.add_sub, ctl.shift_HQ_LQ_Q_1, exps[i]);
        errors++;
      end
    end
    forcedQ = 2'b00;
    runToDone("booth", 18);
    step();
  endtask

  task automatic test_multiply(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input string name);
    forceQ = 1'b0; opA = a; opB = b;
    startOp();
    runToDone(name, 18);
    checks++;
    if (y !== exp) begin
      $display("[TB] FAIL %s_Y: got %h expected %h", name, y, exp);
      errors++;
    end
    step();
  endtask

  task automatic test_startIgnored();
    int loads = 0;
    int doneCount = 0;
    int doneCyc = 0;
    logic [15:0] yAtDone = '0;
    forceQ = 1'b0; opA = 8'd3; opB = 8'd5;
    startOp();
    while (cyc <= 20) begin
      if (cyc > 1 && ctl.load_A) loads++;
      if (done) begin
        doneCount++;
        doneCyc = cyc;
        yAtDone = y;
      end
      start = (cyc == 3 || cyc == 10);
      step();
    end
    start = 1'b0;
    checks++;
    if (loads != 0) begin
      $display("[TB] FAIL ignore_extraLoad: got %0d expected 0", loads);
      errors++;
    end
    checks++;
    if (doneCount != 1 || doneCyc != 18) begin
      $display("[TB] FAIL ignore_done: got %0d pulses last at %0d expected 1 at 18", doneCount, doneCyc);
      errors++;
    end
    checks++;
    if (yAtDone !== 16'h000F) begin
      $display("[TB] FAIL ignore_Y: got %h expected 000f", yAtDone);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    forceQ = 1'b0; opA = 8'h7F; opB = 8'h80;
    start = 1'b1;
    step();
    cyc = 1;
    runToDone("b2b_first", 18);
    checks++;
    if (y !== 16'hC080) begin
      $display("[TB] FAIL b2b_firstY: got %h expected c080", y);
      errors++;
    end
    step();
    checks++;
    if ({ctl, busy, done} !== 7'b0) begin
      $display("[TB] FAIL b2b_idle: got %b expected %b", {ctl, busy, done}, 7'b0);
      errors++;
    end
    step();
    checks++;
    if ({ctl, busy, done} !== 7'b11000_1_0) begin
      $display("[TB] FAIL b2b_relaunch: got %b expected %b", {ctl, busy, done}, 7'b11000_1_0);
      errors++;
    end
    start = 1'b0;
    runToDone("b2b_second", 37);
    checks++;
    if (y !== 16'hC080) begin
      $display("[TB] FAIL b2b_secondY: got %h expected c080", y);
      errors++;
    end
    step();
  endtask

  task automatic test_midReset();
    forceQ = 1'b0; opA = 8'hFD; opB = 8'd5;
    startOp();
    while (cyc < 7) step();
    checks++;
    if (ctl.shift_HQ_LQ_Q_1 !== 1'b1) begin
      $display("[TB] FAIL midrst_inShift: got %b expected 1", ctl.shift_HQ_LQ_Q_1);
      errors++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({ctl, busy, done} !== 7'b0) begin
      $display("[TB] FAIL midrst_async: got %b expected %b", {ctl, busy, done}, 7'b0);
      errors++;
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({ctl, busy, done} !== 7'b0) begin
        $display("[TB] FAIL midrst_held: got %b expected %b", {ctl, busy, done}, 7'b0);
        errors++;
      end
    end
    rst = 1'b1;
    step();
    checks++;
    if ({ctl, busy, done} !== 7'b0) begin
      $display("[TB] FAIL midrst_idleAfter: got %b expected %b", {ctl, busy, done}, 7'b0);
      errors++;
    end
    test_multiply(8'hFD, 8'd5, 16'hFFF1, "midrst_rerun");
  endtask

  initial begin
    $display("[TB] starting mult_controller bench");
    test_reset();
    test_controlTrace();
    test_boothDecode();
    test_multiply(8'd3,  8'd5,  16'h000F, "mul_3x5");
    test_multiply(8'hFD, 8'd5,  16'hFFF1, "mul_m3x5");
    test_multiply(8'h80, 8'h80, 16'h4000, "mul_80x80");
    test_multiply(8'h00, 8'h7F, 16'h0000, "mul_0x7f");
    test_startIgnored();
    test_back_to_back();
    test_midReset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_controller.md
Name: mult_controller

Overview:
- Booth radix-2 sequencing FSM that sits directly upstream of the shift-add multiplier datapath.
- Drives the datapath's mult_control_t bundle and consumes its Q_LSB pair {Q0, Q_-1}.
- Sequences a load, N add/subtract-evaluate steps and N arithmetic shifts, then signals completion.
- Exposes a start/busy/done handshake so the result on the datapath's Y can be captured.

Parameters:
N  8  operand width; the number of Booth iterations performed.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  request a multiply; sampled only in IDLE
Q_LSB  input  2  {LQ[0], Q_1} from the datapath
mult_control  output  mult_control_t  {load_A, load_B, load_add, add_sub, shift_HQ_LQ_Q_1} to the datapath
busy  output  1  high from LOAD through the final SHIFT
done  output  1  one-cycle pulse; the datapath Y is valid in that cycle

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to IDLE and the iteration counter to 0.
  - All mult_control fields, busy and done are 0.
  - Reset mid-operation aborts immediately; no further control pulses are issued.
- States: IDLE, LOAD, EVAL, SHIFT, DONE.
- IDLE:
  - All outputs 0.
  - start=1 at a rising edge -> LOAD.
- LOAD:
  - load_A=1 and load_B=1 for exactly one cycle; counter <= 0.
  - Next state is EVAL.
- EVAL (outputs are Mealy on Q_LSB):
  - Q_LSB=01: load_add=1, add_sub=1 (HQ+M).
  - Q_LSB=10: load_add=1, add_sub=0 (subtract).
  - Q_LSB=00 or 11: load_add=0, add_sub=0.
  - Next state is SHIFT.
- SHIFT:
  - shift_HQ_LQ_Q_1=1 for one cycle; counter <= counter+1.
  - If counter==N-1, next state is DONE; otherwise EVAL.
- DONE:
  - done=1, busy=0, all control fields 0.
  - Next state is IDLE unconditionally.
- Latency: if start is sampled at edge 0, LOAD occupies cycle 1 and EVAL/SHIFT alternate over cycles 2..2N+1. done is high in cycle 2N+2 (cycle 18 for N=8). Total 2N+2 cycles.
- Mutual exclusion: shift_HQ_LQ_Q_1 is never asserted together with load_A, load_B or load_add.
- load_add is only ever asserted in EVAL.
- start handling:
  - start in LOAD/EVAL/SHIFT/DONE is ignored; it is not queued.
  - A level-held start re-launches from IDLE one cycle after DONE.
- Counter: width $clog2(N+1). It never exceeds N-1 while busy and has no wrap-around.
- Unknown Q_LSB (X) in EVAL: treat as the no-op encoding (00) under synthesis; the assertion below flags it.
- Assertions:
  - No overlap of shift with any load field.
  - done is never high for two consecutive cycles.
  - busy and done are never high together.

Decomposition:
- Package mult_pkg:
  - mult_control_t as a packed struct {load_A, load_B, load_add, add_sub, shift_HQ_LQ_Q_1}.
  - mult_state_t enum {IDLE, LOAD, EVAL, SHIFT, DONE}.
  - Booth encoding localparams BOOTH_ADD=2'b01, BOOTH_SUB=2'b10.
- The controller itself has no sub-module.
- Top-level wrapper mult_top instantiates mult_controller and the datapath for integration and testing.

Test Plan:
- Control trace, N=8: assert start one cycle in IDLE with Q_LSB forced 00 -> exact pulse pattern LOAD(A,B), then 8x(EVAL no-op, SHIFT), then done in cycle 18; busy high cycles 1-17.
- Booth decode: force Q_LSB=10 in EVAL -> load_add=1/add_sub=0; force 01 -> load_add=1/add_sub=1; force 11 -> load_add=0.
- Through mult_top with A=3, B=5 -> done pulse and Y=0x000F. With A=-3 (0xFD), B=5 -> Y=0xFFF1.
- Through mult_top with A=0x80, B=0x80 -> Y=0x4000. With A=0, B=0x7F -> Y=0x0000.
- start re-pulsed at cycles 3 and 10 of an operation -> ignored; exactly one done at cycle 18; no second LOAD.
- rst driven 0 during cycle 7 (mid-SHIFT) -> all outputs 0 asynchronously and state IDLE. A new start after release completes normally with a correct Y.
